apb_slave_regs: RTL and testbench
=================================

# apb_slave_regs

APB completer with an internal register bank. It is the responder-side counterpart of the team's APB master on the same 8-bit address and 8-bit data bus. It decodes SETUP/ACCESS phases, inserts a programmable number of wait states, and commits writes or returns read data when it drives `pready`. Out-of-range addresses are flagged with `pslverr`.

## Interface
- `DEPTH`, default 16: number of 8-bit registers, addresses 0..DEPTH-1; legal range 1..256.
- `WAIT_CYCLES`, default 0: wait states inserted per transfer before `pready`; legal range 0..15.
- `pclk` input 1: single clock; all logic on rising edge.
- `preset` input 1: reset, synchronous, active-high.
- `psel` input 1: select from master.
- `penable` input 1: access-phase strobe.
- `pwrite` input 1: 1 = write, 0 = read.
- `paddr` input 8: transfer address.
- `pwdata` input 8: write data.
- `prdata` output 8: read data; valid only while `pready`=1 on a read.
- `pready` output 1: transfer complete this cycle.
- `pslverr` output 1: error response; valid only while `pready`=1.

## Operation
- Registers:
  - `mem[DEPTH]` x 8 bits.
  - `state`: one of IDLE, ACCESS.
  - `cnt`: 4 bits.
  - `addr_q`, `wr_q`, `wdata_q`: captured at SETUP.
- SETUP detect: `psel`=1 and `penable`=0 while in IDLE.
  - Capture `paddr`, `pwrite`, `pwdata` into `addr_q`, `wr_q`, `wdata_q`.
  - Load `cnt` = `WAIT_CYCLES`.
  - Next state ACCESS.
- IDLE, any other input combination (including `penable`=1 without a prior SETUP): stay IDLE; no effect on `mem`.
- ACCESS, `psel`=1, `cnt`!=0: decrement `cnt`; stay ACCESS.
- ACCESS, `psel`=1, `cnt`=0: `pready`=1 this cycle.
  - Write with `addr_q` < `DEPTH`: `mem[addr_q]` <= `wdata_q` at this edge.
  - Next state IDLE.
- ACCESS, `psel`=0 (master abort): next state IDLE, no write, `pready` stays 0.
- Outputs (combinational from registered state):
  - `pready` = (state==ACCESS) & `psel` & `penable` & (`cnt`==0).
  - `pslverr` = `pready` & (`addr_q` >= `DEPTH`).
  - `prdata` = `mem[addr_q]` when `pready` & !`wr_q` & !`pslverr`, else 8'h00.
- Error transfer: no register is modified; reads return 8'h00.
- The captured values are used throughout the transfer. Changes on `paddr`/`pwdata`/`pwrite` during ACCESS are ignored.
- Back-to-back transfers: a SETUP presented in the cycle after completion is accepted normally; there is no mandatory idle cycle.

## Timing
- Reset (`preset`=1 at a rising edge):
  - state IDLE, `cnt`=0, all `mem` entries 8'h00, captured registers 0.
  - Outputs next cycle: `pready`=0, `pslverr`=0, `prdata`=8'h00.
- Reset mid-transfer overrides everything: the transfer is dropped and a pending write is discarded.
- Latency: SETUP in cycle T. ACCESS starts in T+1. `pready`=1 in cycle T+1+`WAIT_CYCLES`. The transfer occupies `WAIT_CYCLES`+2 cycles in total.
- Write data is visible to a read whose SETUP is in the cycle after the write's completion.
- `pready`, `pslverr` and `prdata` are 0 in every cycle other than a completing access cycle.
- `cnt` never underflows; it holds at 0 while the completion condition is evaluated.

## Test plan
- Reset, then read `paddr`=8'h03 (`WAIT_CYCLES`=0) -> `pready`=1 in the first access cycle, `prdata`=8'h00, `pslverr`=0; all outputs 0 during and immediately after reset.
- `WAIT_CYCLES`=0: write 8'hA5 to 8'h05, then read 8'h05 back-to-back -> write completes at T+1, read SETUP at T+2, `prdata`=8'hA5 with `pready` at T+3.
- `WAIT_CYCLES`=2: write 8'h3C to 8'h0F -> `pready` low for two access cycles and high in the third (T+3). Change `paddr` to 8'h00 mid-access -> `mem[8'h0F]`=8'h3C, `mem[8'h00]` unchanged.
- `DEPTH`=16: write 8'hFF to 8'h20 -> `pready`=1 and `pslverr`=1 in the same cycle. A subsequent read of 8'h20 -> `pslverr`=1, `prdata`=8'h00. All 16 registers remain unchanged.
- Abort: `WAIT_CYCLES`=3, write 8'h77 to 8'h02, drop `psel` after one access cycle -> no `pready`, `mem[2]` unchanged, next SETUP accepted normally.
- Assert `preset` during the wait states of a write of 8'h55 to 8'h01 -> state IDLE, no `pready`, a later read of 8'h01 returns 8'h00.

Source files
------------

// File: rtl/apb_slave_regs.sv
// APB completer with an internal 8-bit register bank.
// Captures the transfer at SETUP, inserts WAIT_CYCLES wait states, then
// completes with pready. Writes are committed and read data is returned in
// the completing cycle. Addresses at or above DEPTH complete with pslverr.
module apb_slave_regs #(
   parameter int DEPTH       = 16,
   parameter int WAIT_CYCLES = 0
) (
   input  logic       pclk,
   input  logic       preset,
   input  logic       psel,
   input  logic       penable,
   input  logic       pwrite,
   input  logic [7:0] paddr,
   input  logic [7:0] pwdata,
   output logic [7:0] prdata,
   output logic       pready,
   output logic       pslverr
);

   localparam int         AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [8:0] DEPTH_W = 9'(DEPTH);

   typedef enum logic {IDLE, ACCESS} state_t;

   state_t        state_q, state_d;
   logic [3:0]    cnt_q, cnt_d;
   logic [7:0]    addr_q, addr_d;
   logic [7:0]    wdata_q, wdata_d;
   logic          wr_q, wr_d;
   logic [7:0]    mem_q [DEPTH];

   logic          in_range;
   logic          done;
   logic          mem_we;
   logic [AW-1:0] idx;

   // The compare is one bit wider so DEPTH=256 still works.
   assign in_range = ({1'b0, addr_q} < DEPTH_W);
   assign idx      = addr_q[AW-1:0];
   assign done     = (state_q == ACCESS) && psel && penable && (cnt_q == 4'd0);
   assign mem_we   = done && wr_q && in_range;

   assign pready   = done;
   assign pslverr  = done && !in_range;
   assign prdata   = (done && !wr_q && in_range) ? mem_q[idx] : 8'h00;

   // Next-state: capture at SETUP, count wait states, finish or abort.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      wr_d    = wr_q;
      wdata_d = wdata_q;
      case (state_q)
         IDLE: begin
            if (psel && !penable) begin
               addr_d  = paddr;
               wr_d    = pwrite;
               wdata_d = pwdata;
               cnt_d   = 4'(WAIT_CYCLES);
               state_d = ACCESS;
            end
         end
         ACCESS: begin
            if (!psel) begin
               state_d = IDLE;                // master abort, nothing commits
            end else if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else if (penable) begin
               state_d = IDLE;                // completing cycle
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State, captured transfer and register bank; reset wins over a pending write.
   always_ff @(posedge pclk) begin
      if (preset) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         addr_q  <= 8'h00;
         wr_q    <= 1'b0;
         wdata_q <= 8'h00;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= 8'h00;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         wr_q    <= wr_d;
         wdata_q <= wdata_d;
         if (mem_we) mem_q[idx] <= wdata_q;
      end
   end

endmodule

// File: tb/tb_apb_slave_regs.sv
// Bench for apb_slave_regs: three instances (wait states 0, 2, 3, DEPTH 16)
// driven by directed scenarios and then random transfers, checked against a
// per-instance array model of the register contents.
module tb_apb_slave_regs;

   logic       pclk;
   logic       preset;
   logic       psel    [3];
   logic       penable [3];
   logic       pwrite  [3];
   logic [7:0] paddr   [3];
   logic [7:0] pwdata  [3];
   logic [7:0] prdata  [3];
   logic       pready  [3];
   logic       pslverr [3];

   int         WT [3] = '{0, 2, 3};
   logic [7:0] mdl [3][16];
   int         checks = 0;
   int         errors = 0;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      apb_slave_regs #(
         .DEPTH       (16),
         .WAIT_CYCLES ((g == 0) ? 0 : ((g == 1) ? 2 : 3))
      ) u_dut (
         .pclk    (pclk),
         .preset  (preset),
         .psel    (psel[g]),
         .penable (penable[g]),
         .pwrite  (pwrite[g]),
         .paddr   (paddr[g]),
         .pwdata  (pwdata[g]),
         .prdata  (prdata[g]),
         .pready  (pready[g]),
         .pslverr (pslverr[g])
      );
   end

   initial pclk = 1'b0;
   always #5 pclk = ~pclk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clr_model();
      for (int k = 0; k < 3; k++)
         for (int i = 0; i < 16; i++) mdl[k][i] = 8'h00;
   endtask

   // Outputs of instance k must be all zero this cycle.
   task automatic chk_quiet(input string tag, input int k);
      chk({tag, ".pready"},  {7'd0, pready[k]},  8'h00);
      chk({tag, ".pslverr"}, {7'd0, pslverr[k]}, 8'h00);
      chk({tag, ".prdata"},  prdata[k],          8'h00);
   endtask

   // One idle cycle on instance k. Called just after a rising edge.
   task automatic idle(input int k);
      psel[k] = 1'b0; penable[k] = 1'b0;
      @(negedge pclk);
      chk_quiet("idle", k);
      @(posedge pclk); #1;
   endtask

   // Full transfer on instance k. ab/rs: access-cycle index at which psel is
   // dropped / preset is raised (-1 = never). scr scrambles the address,
   // data and direction lines during the access phase.
   task automatic xfer(input int k, input bit wr, input logic [7:0] a, input logic [7:0] d,
                       input int ab, input int rs, input bit scr);
      bit err;
      logic [7:0] exp_rd;
      err = (a >= 8'd16);
      psel[k] = 1'b1; penable[k] = 1'b0; pwrite[k] = wr; paddr[k] = a; pwdata[k] = d;
      @(negedge pclk);
      chk_quiet("setup", k);
      @(posedge pclk); #1;
      for (int i = 0; i <= WT[k]; i++) begin
         penable[k] = 1'b1;
         if (scr) begin
            paddr[k] = 8'h00; pwdata[k] = ~d; pwrite[k] = ~wr;
         end
         if (i == ab) begin
            psel[k] = 1'b0; penable[k] = 1'b0;
            @(negedge pclk);
            chk_quiet("abort", k);
            @(posedge pclk); #1;
            return;
         end
         if (i == rs) begin
            preset = 1'b1;
            @(negedge pclk);
            chk_quiet("rst_mid", k);
            @(posedge pclk); #1;
            preset = 1'b0; psel[k] = 1'b0; penable[k] = 1'b0;
            clr_model();
            return;
         end
         @(negedge pclk);
         if (i < WT[k]) begin
            chk_quiet("wait", k);
         end else begin
            exp_rd = (!wr && !err) ? mdl[k][a[3:0]] : 8'h00;
            chk("done.pready",  {7'd0, pready[k]},  8'h01);
            chk("done.pslverr", {7'd0, pslverr[k]}, {7'd0, err});
            chk("done.prdata",  prdata[k],          exp_rd);
            if (wr && !err) mdl[k][a[3:0]] = d;
         end
         @(posedge pclk); #1;
      end
      psel[k] = 1'b0; penable[k] = 1'b0;
   endtask

   initial begin
      int k, ab;
      bit wr;
      logic [7:0] a, d;
      preset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         psel[i] = 1'b0; penable[i] = 1'b0; pwrite[i] = 1'b0;
         paddr[i] = 8'h00; pwdata[i] = 8'h00;
      end
      clr_model();

      // Reset: quiet during and after.
      @(posedge pclk); #1;
      @(negedge pclk);
      for (int i = 0; i < 3; i++) chk_quiet("in_reset", i);
      @(posedge pclk); #1;
      preset = 1'b0;
      idle(0);

      // Read after reset, no wait states.
      xfer(0, 1'b0, 8'h03, 8'h00, -1, -1, 1'b0);
      // Write then back-to-back read.
      xfer(0, 1'b1, 8'h05, 8'hA5, -1, -1, 1'b0);
      xfer(0, 1'b0, 8'h05, 8'h00, -1, -1, 1'b0);
      // Two wait states, bus lines change during access.
      xfer(1, 1'b1, 8'h0F, 8'h3C, -1, -1, 1'b1);
      xfer(1, 1'b0, 8'h0F, 8'h00, -1, -1, 1'b0);
      xfer(1, 1'b0, 8'h00, 8'h00, -1, -1, 1'b0);
      // Out of range write and read; bank untouched.
      xfer(0, 1'b1, 8'h20, 8'hFF, -1, -1, 1'b0);
      xfer(0, 1'b0, 8'h20, 8'h00, -1, -1, 1'b0);
      for (int i = 0; i < 16; i++) xfer(0, 1'b0, 8'(i), 8'h00, -1, -1, 1'b0);
      // Abort after one access cycle, then normal transfer.
      xfer(2, 1'b1, 8'h02, 8'h77, 1, -1, 1'b0);
      xfer(2, 1'b0, 8'h02, 8'h00, -1, -1, 1'b0);
      // Reset during wait states drops the write.
      xfer(2, 1'b1, 8'h01, 8'h55, -1, 1, 1'b0);
      idle(2);
      xfer(2, 1'b0, 8'h01, 8'h00, -1, -1, 1'b0);

      // Random transfers.
      for (int n = 0; n < 80; n++) begin
         k  = int'($urandom_range(2));
         wr = 1'($urandom_range(1));
         a  = 8'($urandom_range(21));
         d  = 8'($urandom);
         ab = ($urandom_range(7) == 0) ? int'($urandom_range(WT[k])) : -1;
         xfer(k, wr, a, d, ab, -1, 1'($urandom_range(1)));
         if ($urandom_range(3) == 0) idle(k);
      end
      // Final sweep of every register of every instance.
      for (int j = 0; j < 3; j++)
         for (int i = 0; i < 16; i++) xfer(j, 1'b0, 8'(i), 8'h00, -1, -1, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
